// File: rtl/cmd_wr_arbiter.sv
// Round-robin arbiter sharing the command-queue FIFO write port between N_REQ requesters.
// Optional build macro CMD_ARB_WB_PRIORITY_EN gives requester 0 (issuer writeback) strict priority.
module cmd_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 64,
  parameter int CNT_W = 16,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*WIDTH-1:0] i_cmd,
  output logic [N_REQ-1:0]       o_ack,
  input  logic                   i_fifo_full,
  output logic                   o_wr,
  output logic [WIDTH-1:0]       o_cmd,
  output logic                   o_busy,
  output logic [ID_W-1:0]        o_grant_id,
  output logic [CNT_W-1:0]       o_wr_count
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [N_REQ-1:0]  cand;
  logic              rr_found;
  logic [ID_W-1:0]   rr_idx;
  logic [ID_W-1:0]   scan_idx;
  logic              sel_found;
  logic [ID_W-1:0]   sel_idx;
  logic [WIDTH-1:0]  sel_cmd;
  logic              take;
  logic [ID_W-1:0]   ptr_nxt;

  // Round-robin scan: first candidate at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cand     = i_req;
    rr_found = 1'b0;
    rr_idx   = '0;
    scan_idx = '0;
`ifdef CMD_ARB_WB_PRIORITY_EN
    cand[0]  = 1'b0;
`endif
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx = ID_W'((int'(rr_ptr) + i) % N_REQ);
      if (!rr_found && cand[scan_idx]) begin
        rr_found = 1'b1;
        rr_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel_found = rr_found;
    sel_idx   = rr_idx;
`ifdef CMD_ARB_WB_PRIORITY_EN
    if (i_req[0]) begin
      sel_found = 1'b1;
      sel_idx   = '0;
    end
`endif
    sel_cmd = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_idx == ID_W'(k)) sel_cmd = i_cmd[k*WIDTH +: WIDTH];
    end
  end

  assign take   = (state == IDLE) && sel_found && !i_fifo_full;
  assign o_busy = (state == WRITE);
  assign o_wr   = o_busy && !i_fifo_full;
  assign o_ack  = o_wr ? (N_REQ'(1) << o_grant_id) : '0;

  // Writeback grants leave the pointer alone so requesters 1..N_REQ-1 keep their rotation.
  always_comb begin
    ptr_nxt = rr_ptr;
`ifdef CMD_ARB_WB_PRIORITY_EN
    if (o_grant_id != '0)
`endif
      ptr_nxt = (o_grant_id == ID_W'(N_REQ - 1)) ? '0 : o_grant_id + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = WRITE;
      WRITE:   if (!i_fifo_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rr_ptr     <= '0;
      o_cmd      <= '0;
      o_grant_id <= '0;
      o_wr_count <= '0;
    end else begin
      if (take) begin
        o_grant_id <= sel_idx;
        o_cmd      <= sel_cmd;
      end
      if (o_wr) begin
        o_wr_count <= o_wr_count + 1'b1;
        rr_ptr     <= ptr_nxt;
      end
    end
  end

endmodule
